// File: rtl/mem_access_stage_if.sv
// Data-memory port between the MEM stage and a variable-latency data memory.
// The stage (master) holds mem_req and all request fields until mem_ack.
// mem_ack and mem_rdata come from the memory (slave); read data is valid in the ack cycle.
//   mem_req   : request valid
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word-aligned byte address
//   mem_wdata : lane-replicated store data
//   mem_be    : byte enables
//   mem_ack   : request completed
//   mem_rdata : read word
interface mem_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage of the pipelined RV32I core.
// It issues loads and stores from the EX/MEM register over a req/ack data-memory port.
// It steers store bytes onto lanes and sign- or zero-extends load data.
// It flags misaligned or illegal accesses and loads the MEM/WB pipeline register.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   EN                  : MEM/WB load enable from the hazard unit
//   *_M inputs          : EX/MEM register outputs
//   ALUResData          : unregistered forward of ALUResult_M
//   mem                 : data-memory port (master side)
//   stall_mem           : access outstanding; freezes the earlier pipeline stages
//   mem_fault, fault_pc : one-cycle fault pulse and the PC of the faulting instruction
//   *_W outputs         : MEM/WB register
module mem_access_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  EN,
    input  logic [XLEN-1:0]       ALUResult_M,
    input  logic [XLEN-1:0]       WriteData_M,
    input  logic [4:0]            DR_num_M,
    input  logic [XLEN-1:0]       PC_plus_4_M,
    input  logic [XLEN-1:0]       PC_M,
    input  logic                  RegWrite_M,
    input  logic [1:0]            ResultSrc_M,
    input  logic                  MemWrite_M,
    input  logic                  MemRead_M,
    input  logic [2:0]            funct3_M,
    output logic [XLEN-1:0]       ALUResData,
    mem_access_stage_if.master    mem,
    output logic                  stall_mem,
    output logic                  mem_fault,
    output logic [XLEN-1:0]       fault_pc,
    output logic                  RegWrite_W,
    output logic [1:0]            ResultSrc_W,
    output logic [4:0]            DR_num_W,
    output logic [XLEN-1:0]       ALUResult_W,
    output logic [XLEN-1:0]       ReadData_W,
    output logic [XLEN-1:0]       PC_plus_4_W
);

    typedef enum logic {StIdle, StWait} state_e;

    state_e      state_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic        mem_fault_q;
    logic [31:0] fault_pc_q;
    logic        reg_write_q;
    logic [1:0]  result_src_q;
    logic [4:0]  dr_num_q;
    logic [31:0] alu_result_q;
    logic [31:0] read_data_q;
    logic [31:0] pc_plus_4_q;

    logic        access;
    logic        is_write;
    logic [1:0]  off;
    logic        fault;
    logic        fault_idle;
    logic        in_wait;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        cur_load;
    logic [2:0]  cur_funct3;
    logic [1:0]  cur_off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] read_data_d;

    assign ALUResData = ALUResult_M;

    // Request decode from the live EX/MEM fields. A write wins when both MemRead and MemWrite are set.
    always_comb begin
        access    = MemRead_M | MemWrite_M;
        is_write  = MemWrite_M;
        off       = ALUResult_M[1:0];
        fault     = 1'b0;
        req_be    = 4'hF;
        req_wdata = WriteData_M;
        if (is_write) begin
            unique case (funct3_M)
                3'b000: begin
                    req_be    = 4'b0001 << off;
                    req_wdata = {4{WriteData_M[7:0]}};
                end
                3'b001: begin
                    req_be    = 4'b0011 << off;
                    req_wdata = {2{WriteData_M[15:0]}};
                    fault     = off[0];
                end
                3'b010: fault = |off;
                default: fault = 1'b1;
            endcase
        end else begin
            unique case (funct3_M)
                3'b000, 3'b100: fault = 1'b0;
                3'b001, 3'b101: fault = off[0];
                3'b010:         fault = |off;
                default:        fault = 1'b1;
            endcase
        end
        fault = fault & access;
    end

    assign in_wait    = (state_q == StWait);
    assign fault_idle = ~in_wait & fault;

    // In WAIT the request is replayed from the latched fields, so it stays stable until ack.
    always_comb begin
        mem.mem_req   = ~reset & (in_wait | (access & ~fault));
        mem.mem_we    = in_wait ? we_q    : is_write;
        mem.mem_addr  = in_wait ? addr_q  : {ALUResult_M[31:2], 2'b00};
        mem.mem_wdata = in_wait ? wdata_q : req_wdata;
        mem.mem_be    = in_wait ? be_q    : (is_write ? req_be : 4'hF);
        stall_mem     = ~reset & ((~in_wait & access & ~fault & ~mem.mem_ack) |
                                  (in_wait & ~mem.mem_ack));
    end

    // Load extraction and extension of the read word.
    always_comb begin
        cur_load   = in_wait ? ~we_q    : (MemRead_M & ~MemWrite_M);
        cur_funct3 = in_wait ? funct3_q : funct3_M;
        cur_off    = in_wait ? off_q    : off;
        unique case (cur_off)
            2'd0:    ld_byte = mem.mem_rdata[7:0];
            2'd1:    ld_byte = mem.mem_rdata[15:8];
            2'd2:    ld_byte = mem.mem_rdata[23:16];
            default: ld_byte = mem.mem_rdata[31:24];
        endcase
        ld_half = cur_off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        unique case (cur_funct3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            3'b010:  ld_ext = mem.mem_rdata;
            default: ld_ext = 32'd0;
        endcase
        read_data_d = cur_load ? ld_ext : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            mem_fault_q  <= 1'b0;
            fault_pc_q   <= 32'd0;
            reg_write_q  <= 1'b0;
            result_src_q <= 2'd0;
            dr_num_q     <= 5'd0;
            alu_result_q <= 32'd0;
            read_data_q  <= 32'd0;
            pc_plus_4_q  <= 32'd0;
        end else begin
            mem_fault_q <= fault_idle;
            if (fault_idle) begin
                fault_pc_q <= PC_M;
            end

            unique case (state_q)
                StIdle: begin
                    if (access && !fault && !mem.mem_ack) begin
                        state_q  <= StWait;
                        we_q     <= is_write;
                        addr_q   <= {ALUResult_M[31:2], 2'b00};
                        wdata_q  <= req_wdata;
                        be_q     <= is_write ? req_be : 4'hF;
                        funct3_q <= funct3_M;
                        off_q    <= off;
                    end
                end
                default: begin
                    if (mem.mem_ack) begin
                        state_q <= StIdle;
                    end
                end
            endcase

            // A stalled or faulting instruction leaves a cleared bubble behind.
            if (EN) begin
                if (stall_mem || fault_idle) begin
                    reg_write_q  <= 1'b0;
                    result_src_q <= 2'd0;
                    dr_num_q     <= 5'd0;
                    alu_result_q <= 32'd0;
                    read_data_q  <= 32'd0;
                    pc_plus_4_q  <= 32'd0;
                end else begin
                    reg_write_q  <= RegWrite_M;
                    result_src_q <= ResultSrc_M;
                    dr_num_q     <= DR_num_M;
                    alu_result_q <= ALUResult_M;
                    read_data_q  <= read_data_d;
                    pc_plus_4_q  <= PC_plus_4_M;
                end
            end
        end
    end

    assign mem_fault   = mem_fault_q;
    assign fault_pc    = fault_pc_q;
    assign RegWrite_W  = reg_write_q;
    assign ResultSrc_W = result_src_q;
    assign DR_num_W    = dr_num_q;
    assign ALUResult_W = alu_result_q;
    assign ReadData_W  = read_data_q;
    assign PC_plus_4_W = pc_plus_4_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        reset, EN;
    logic [31:0] ALUResult_M, WriteData_M, PC_plus_4_M, PC_M;
    logic [4:0]  DR_num_M;
    logic        RegWrite_M, MemWrite_M, MemRead_M;
    logic [1:0]  ResultSrc_M;
    logic [2:0]  funct3_M;
    logic [31:0] ALUResData, fault_pc, ALUResult_W, ReadData_W, PC_plus_4_W;
    logic        stall_mem, mem_fault, RegWrite_W;
    logic [1:0]  ResultSrc_W;
    logic [4:0]  DR_num_W;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_stage_if mif ();

    mem_access_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .EN          (EN),
        .ALUResult_M (ALUResult_M),
        .WriteData_M (WriteData_M),
        .DR_num_M    (DR_num_M),
        .PC_plus_4_M (PC_plus_4_M),
        .PC_M        (PC_M),
        .RegWrite_M  (RegWrite_M),
        .ResultSrc_M (ResultSrc_M),
        .MemWrite_M  (MemWrite_M),
        .MemRead_M   (MemRead_M),
        .funct3_M    (funct3_M),
        .ALUResData  (ALUResData),
        .mem         (mif),
        .stall_mem   (stall_mem),
        .mem_fault   (mem_fault),
        .fault_pc    (fault_pc),
        .RegWrite_W  (RegWrite_W),
        .ResultSrc_W (ResultSrc_W),
        .DR_num_W    (DR_num_W),
        .ALUResult_W (ALUResult_W),
        .ReadData_W  (ReadData_W),
        .PC_plus_4_W (PC_plus_4_W)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ALUResult_M = 32'd0; WriteData_M = 32'd0; DR_num_M = 5'd0;
        PC_plus_4_M = 32'd0; PC_M = 32'd0; RegWrite_M = 1'b0; ResultSrc_M = 2'd0;
        MemWrite_M = 1'b0; MemRead_M = 1'b0; funct3_M = 3'd0;
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'd0;
    endtask

    initial begin
        reset = 1'b1;
        EN    = 1'b1;
        idle_inputs();
        tick();
        tick();
        #1;
        check("reset_req", 32'(mif.mem_req), 32'd0);
        check("reset_stall", 32'(stall_mem), 32'd0);
        check("reset_regwrite_w", 32'(RegWrite_W), 32'd0);
        check("reset_readdata_w", ReadData_W, 32'd0);
        check("reset_fault", 32'(mem_fault), 32'd0);
        check("reset_fault_pc", fault_pc, 32'd0);
        reset = 1'b0;
        tick();

        // SW, zero-wait
        MemWrite_M = 1'b1; funct3_M = 3'b010; ALUResult_M = 32'h100;
        WriteData_M = 32'hDEADBEEF; mif.mem_ack = 1'b1;
        #1;
        check("sw_req", 32'(mif.mem_req), 32'd1);
        check("sw_we", 32'(mif.mem_we), 32'd1);
        check("sw_addr", mif.mem_addr, 32'h100);
        check("sw_be", 32'(mif.mem_be), 32'hF);
        check("sw_wdata", mif.mem_wdata, 32'hDEADBEEF);
        check("sw_stall", 32'(stall_mem), 32'd0);
        check("sw_forward", ALUResData, 32'h100);
        tick();
        check("sw_regwrite_w", 32'(RegWrite_W), 32'd0);
        check("sw_aluresult_w", ALUResult_W, 32'h100);

        // SB, zero-wait
        funct3_M = 3'b000; ALUResult_M = 32'h103; WriteData_M = 32'h000000A5;
        #1;
        check("sb_addr", mif.mem_addr, 32'h100);
        check("sb_be", 32'(mif.mem_be), 32'b1000);
        check("sb_wdata", mif.mem_wdata, 32'hA5A5A5A5);
        check("sb_stall", 32'(stall_mem), 32'd0);
        tick();

        // LB, ack after three stall cycles
        MemWrite_M = 1'b0; MemRead_M = 1'b1; funct3_M = 3'b000; ALUResult_M = 32'h202;
        RegWrite_M = 1'b1; DR_num_M = 5'd5; ResultSrc_M = 2'b01; PC_plus_4_M = 32'h104;
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'h00800000;
        #1;
        check("lb_req", 32'(mif.mem_req), 32'd1);
        check("lb_we", 32'(mif.mem_we), 32'd0);
        check("lb_be", 32'(mif.mem_be), 32'hF);
        check("lb_addr", mif.mem_addr, 32'h200);
        check("lb_stall_c1", 32'(stall_mem), 32'd1);
        tick();
        check("lb_stall_c2", 32'(stall_mem), 32'd1);
        check("lb_bubble_alu_w", ALUResult_W, 32'd0);
        check("lb_bubble_rw_w", 32'(RegWrite_W), 32'd0);
        tick();
        check("lb_stall_c3", 32'(stall_mem), 32'd1);
        tick();
        mif.mem_ack = 1'b1;
        #1;
        check("lb_stall_ack", 32'(stall_mem), 32'd0);
        check("lb_req_ack", 32'(mif.mem_req), 32'd1);
        tick();
        check("lb_readdata_w", ReadData_W, 32'hFFFFFF80);
        check("lb_regwrite_w", 32'(RegWrite_W), 32'd1);
        check("lb_dr_w", 32'(DR_num_W), 32'd5);
        check("lb_resultsrc_w", 32'(ResultSrc_W), 32'd1);
        check("lb_pc4_w", PC_plus_4_W, 32'h104);

        // LBU, same latency; a disturbed address in WAIT must not leak onto the port
        funct3_M = 3'b100; mif.mem_ack = 1'b0;
        #1;
        check("lbu_stall_c1", 32'(stall_mem), 32'd1);
        tick();
        ALUResult_M = 32'h500;
        #1;
        check("lbu_addr_held", mif.mem_addr, 32'h200);
        check("lbu_stall_c2", 32'(stall_mem), 32'd1);
        ALUResult_M = 32'h202;
        tick();
        check("lbu_stall_c3", 32'(stall_mem), 32'd1);
        tick();
        mif.mem_ack = 1'b1;
        tick();
        check("lbu_readdata_w", ReadData_W, 32'h00000080);

        // Misaligned LW
        funct3_M = 3'b010; ALUResult_M = 32'h301; PC_M = 32'h40; mif.mem_ack = 1'b0;
        #1;
        check("mis_req", 32'(mif.mem_req), 32'd0);
        check("mis_stall", 32'(stall_mem), 32'd0);
        tick();
        check("mis_fault", 32'(mem_fault), 32'd1);
        check("mis_fault_pc", fault_pc, 32'h40);
        check("mis_regwrite_w", 32'(RegWrite_W), 32'd0);
        idle_inputs();
        tick();
        check("mis_fault_pulse", 32'(mem_fault), 32'd0);
        check("mis_fault_pc_hold", fault_pc, 32'h40);

        // Illegal load funct3 faults even when aligned
        MemRead_M = 1'b1; funct3_M = 3'b011; ALUResult_M = 32'h300; PC_M = 32'h44;
        #1;
        check("ill_req", 32'(mif.mem_req), 32'd0);
        tick();
        check("ill_fault", 32'(mem_fault), 32'd1);
        check("ill_fault_pc", fault_pc, 32'h44);
        idle_inputs();
        tick();

        // Reset while in WAIT with a coincident ack
        MemRead_M = 1'b1; funct3_M = 3'b001; ALUResult_M = 32'h202; RegWrite_M = 1'b1;
        DR_num_M = 5'd9; mif.mem_rdata = 32'h12345678;
        #1;
        check("rst_lh_stall", 32'(stall_mem), 32'd1);
        tick();
        tick();
        reset = 1'b1; mif.mem_ack = 1'b1;
        #1;
        check("rst_req", 32'(mif.mem_req), 32'd0);
        check("rst_stall", 32'(stall_mem), 32'd0);
        tick();
        reset = 1'b0;
        idle_inputs();
        #1;
        check("rst_regwrite_w", 32'(RegWrite_W), 32'd0);
        check("rst_readdata_w", ReadData_W, 32'd0);
        check("rst_dr_w", 32'(DR_num_W), 32'd0);
        check("rst_fault_pc", fault_pc, 32'd0);
        check("rst_idle_req", 32'(mif.mem_req), 32'd0);
        check("rst_idle_stall", 32'(stall_mem), 32'd0);

        // Back-to-back: LW with two stall cycles, then SH zero-wait
        MemRead_M = 1'b1; funct3_M = 3'b010; ALUResult_M = 32'h400; RegWrite_M = 1'b1;
        DR_num_M = 5'd7; ResultSrc_M = 2'b01; PC_plus_4_M = 32'h200;
        mif.mem_rdata = 32'h12345678;
        #1;
        check("b2b_lw_addr", mif.mem_addr, 32'h400);
        check("b2b_lw_stall1", 32'(stall_mem), 32'd1);
        tick();
        check("b2b_lw_stall2", 32'(stall_mem), 32'd1);
        tick();
        mif.mem_ack = 1'b1;
        #1;
        check("b2b_lw_stall_ack", 32'(stall_mem), 32'd0);
        tick();
        check("b2b_lw_readdata_w", ReadData_W, 32'h12345678);
        check("b2b_lw_regwrite_w", 32'(RegWrite_W), 32'd1);
        check("b2b_lw_dr_w", 32'(DR_num_W), 32'd7);
        MemRead_M = 1'b0; MemWrite_M = 1'b1; funct3_M = 3'b001; ALUResult_M = 32'h2;
        WriteData_M = 32'h0000BEEF; RegWrite_M = 1'b0; DR_num_M = 5'd0;
        #1;
        check("b2b_sh_req", 32'(mif.mem_req), 32'd1);
        check("b2b_sh_addr", mif.mem_addr, 32'h0);
        check("b2b_sh_be", 32'(mif.mem_be), 32'b1100);
        check("b2b_sh_wdata", mif.mem_wdata, 32'hBEEFBEEF);
        check("b2b_sh_stall", 32'(stall_mem), 32'd0);
        tick();
        check("b2b_sh_alu_w", ALUResult_W, 32'h2);
        check("b2b_sh_readdata_w", ReadData_W, 32'd0);
        check("b2b_sh_regwrite_w", 32'(RegWrite_W), 32'd0);

        // EN low holds MEM/WB
        EN = 1'b0; funct3_M = 3'b010; ALUResult_M = 32'h10; RegWrite_M = 1'b1;
        tick();
        check("hold_alu_w", ALUResult_W, 32'h2);
        check("hold_regwrite_w", 32'(RegWrite_W), 32'd0);
        EN = 1'b1;
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
